// File: rtl/uart_pkg.sv
// Shared UART definitions: 8N1 frame constants and receiver FSM states.
package uart_pkg;

  localparam int unsigned CLK_PER_BIT_DEF = 868;
  localparam int unsigned DATA_BITS       = 8;
  localparam logic        STOP_LEVEL      = 1'b1;
  localparam logic        IDLE_LEVEL      = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-entry valid/ready output buffer and sticky
// framing/overrun error flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_PER_BIT = CLK_PER_BIT_DEF,
  parameter int unsigned CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       busy,
  output logic       ferr,
  output logic       oerr,
  input  logic       err_clr
);

  localparam int unsigned IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLK_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);

  logic                 rxs;
  rx_state_t            state, state_next;
  logic [CNT_W-1:0]     cnt, cnt_next;
  logic [IDX_W-1:0]     idx, idx_next;
  logic [DATA_BITS-1:0] sreg, sreg_next;
  logic                 load, set_ferr, set_oerr;

  sync2 #(.RST_VAL(IDLE_LEVEL)) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (rxd),
    .q    (rxs)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      sreg       <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      ferr       <= 1'b0;
      oerr       <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      idx        <= idx_next;
      sreg       <= sreg_next;
      data       <= load ? sreg : data;
      // A same-cycle accept and load keeps the buffer full with the new byte.
      data_valid <= load | (data_valid & ~data_ready);
      busy       <= (state_next != IDLE);
      ferr       <= set_ferr | (ferr & ~err_clr);
      oerr       <= set_oerr | (oerr & ~err_clr);
    end
  end

  // Bit timing: cnt counts down to 0, where the line is sampled and cnt reloaded.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idx_next   = idx;
    sreg_next  = sreg;
    load       = 1'b0;
    set_ferr   = 1'b0;
    set_oerr   = 1'b0;
    case (state)
      IDLE: begin
        if (rxs != IDLE_LEVEL) begin
          state_next = START;
          cnt_next   = HALF_LOAD;
        end
      end
      START: begin
        if (cnt != '0) begin
          cnt_next = cnt - CNT_W'(1);
        end else if (rxs == IDLE_LEVEL) begin
          state_next = IDLE;
        end else begin
          state_next = DATA;
          cnt_next   = FULL_LOAD;
          idx_next   = '0;
        end
      end
      DATA: begin
        if (cnt != '0) begin
          cnt_next = cnt - CNT_W'(1);
        end else begin
          sreg_next = {rxs, sreg[DATA_BITS-1:1]};
          cnt_next  = FULL_LOAD;
          if (idx == LAST_IDX) state_next = STOP;
          else                 idx_next   = idx + IDX_W'(1);
        end
      end
      STOP: begin
        if (cnt != '0) begin
          cnt_next = cnt - CNT_W'(1);
        end else if (rxs == STOP_LEVEL) begin
          state_next = IDLE;
          if (!data_valid || data_ready) load     = 1'b1;
          else                           set_oerr = 1'b1;
        end else begin
          state_next = BREAK;
          set_ferr   = 1'b1;
        end
      end
      BREAK: begin
        // Hold here until the line returns idle so a stuck-low line cannot retrigger.
        if (rxs == IDLE_LEVEL) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames
// checked against a frame-level reference model.
module tb_uart_rx;

  localparam int unsigned CPB = 16;
  // Line fall to data_valid: 2 sync cycles, half bit, 9 bit periods, 1 register cycle.
  localparam int LAT       = 2 + CPB / 2 + 9 * CPB + 1;
  localparam int STOP_SMPL = LAT - 1;

  logic       clk;
  logic       rstn;
  logic       rxd;
  logic [7:0] data;
  logic       data_valid;
  logic       data_ready;
  logic       busy;
  logic       ferr;
  logic       oerr;
  logic       err_clr;

  int         checks;
  int         errors;
  int         cyc;
  int         fall_cyc;
  bit         rand_ready;
  logic       dv_d;
  int         busy_run;
  int         busy_max;
  int         rise_q[$];
  logic [7:0] acc_q[$];
  logic [7:0] exp_q[$];
  int         exp_rise_q[$];

  uart_rx #(.CLK_PER_BIT(CPB), .CNT_W(8)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .rxd        (rxd),
    .data       (data),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .busy       (busy),
    .ferr       (ferr),
    .oerr       (oerr),
    .err_clr    (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe handshakes, data_valid rises and busy run lengths between edges.
  always @(negedge clk) begin
    if (data_valid && !dv_d) rise_q.push_back(cyc);
    if (data_valid && data_ready) acc_q.push_back(data);
    if (busy) busy_run <= busy_run + 1;
    else      busy_run <= 0;
    if (busy && busy_run + 1 > busy_max) busy_max <= busy_run + 1;
    dv_d <= data_valid;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) data_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_lvl, input int stop_len);
    rxd      = 1'b0;
    fall_cyc = cyc;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) tick();
    end
    rxd = stop_lvl;
    repeat (stop_len) tick();
    rxd = 1'b1;
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] b);
    check({tag, "_avail"}, 32'(acc_q.size() > 0), 32'd1);
    if (acc_q.size() > 0) check(tag, 32'(acc_q.pop_front()), 32'(b));
  endtask

  task automatic expect_rise(input string tag, input int at);
    check({tag, "_avail"}, 32'(rise_q.size() > 0), 32'd1);
    if (rise_q.size() > 0) check(tag, 32'(rise_q.pop_front()), 32'(at));
  endtask

  initial begin
    logic [7:0] b;
    int         gap;
    checks     = 0;
    errors     = 0;
    cyc        = 0;
    rand_ready = 1'b0;
    busy_run   = 0;
    busy_max   = 0;
    dv_d       = 1'b0;
    rstn       = 1'b0;
    rxd        = 1'b1;
    data_ready = 1'b0;
    err_clr    = 1'b0;
    repeat (3) tick();
    check("rst_data", 32'(data), 32'h0);
    check("rst_valid", 32'(data_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_flags", 32'({ferr, oerr}), 32'h0);
    rstn = 1'b1;
    repeat (5) tick();

    // Basic frame with exact latency and one-cycle valid.
    data_ready = 1'b1;
    send_frame(8'hA5, 1'b1, CPB);
    expect_rise("a5_rise", fall_cyc + LAT);
    expect_byte("a5_data", 8'hA5);
    check("a5_valid_low", 32'(data_valid), 32'h0);
    check("a5_flags", 32'({ferr, oerr}), 32'h0);
    repeat (4) tick();

    // Short low glitch on the line.
    busy_max = 0;
    rxd = 1'b0;
    repeat (4) tick();
    rxd = 1'b1;
    repeat (20) tick();
    check("glitch_busy_le8", 32'(busy_max <= 8 && busy_max > 0), 32'd1);
    check("glitch_idle", 32'(busy), 32'h0);
    check("glitch_no_rise", 32'(rise_q.size()), 32'd0);
    check("glitch_flags", 32'({ferr, oerr}), 32'h0);

    // Framing error, break, recovery, clear.
    send_frame(8'h3C, 1'b0, 2 * CPB);
    repeat (6) tick();
    check("ferr_set", 32'(ferr), 32'd1);
    check("ferr_no_rise", 32'(rise_q.size()), 32'd0);
    check("ferr_no_byte", 32'(acc_q.size()), 32'd0);
    send_frame(8'h01, 1'b1, CPB);
    repeat (4) tick();
    expect_byte("after_ferr", 8'h01);
    check("ferr_sticky", 32'(ferr), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("ferr_clr", 32'(ferr), 32'd0);
    rise_q.delete();

    // Overrun with a blocked consumer.
    data_ready = 1'b0;
    send_frame(8'h11, 1'b1, CPB);
    send_frame(8'h22, 1'b1, CPB);
    check("ovr_data", 32'(data), 32'h11);
    check("ovr_valid", 32'(data_valid), 32'd1);
    check("ovr_oerr", 32'(oerr), 32'd1);
    check("ovr_ferr", 32'(ferr), 32'd0);
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    check("ovr_drain_valid", 32'(data_valid), 32'd0);
    expect_byte("ovr_byte", 8'h11);
    check("ovr_only_one", 32'(acc_q.size()), 32'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("oerr_clr", 32'(oerr), 32'd0);

    // Accept on the exact stop-sample cycle while a byte is held.
    send_frame(8'h66, 1'b1, CPB);
    repeat (4) tick();
    rise_q.delete();
    fork
      send_frame(8'h55, 1'b1, CPB);
      begin
        repeat (STOP_SMPL) tick();
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
        check("swap_valid", 32'(data_valid), 32'd1);
        check("swap_data", 32'(data), 32'h55);
      end
    join
    expect_byte("swap_old", 8'h66);
    check("swap_oerr", 32'(oerr), 32'd0);
    check("swap_no_new_rise", 32'(rise_q.size()), 32'd0);
    data_ready = 1'b1;
    tick();
    expect_byte("swap_new", 8'h55);

    // Reset in the middle of a frame.
    fork
      send_frame(8'hF0, 1'b1, CPB);
      begin
        repeat (CPB + 3 * CPB + 6) tick();
        rstn = 1'b0;
        #1;
        check("mid_rst_data", 32'(data), 32'h0);
        check("mid_rst_valid", 32'(data_valid), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_flags", 32'({ferr, oerr}), 32'h0);
      end
    join
    repeat (3) tick();
    rstn = 1'b1;
    repeat (3) tick();
    rise_q.delete();
    acc_q.delete();
    send_frame(8'h0F, 1'b1, CPB);
    repeat (4) tick();
    expect_rise("post_rst_rise", fall_cyc + LAT);
    expect_byte("post_rst_data", 8'h0F);

    // Randomized frames, idle gaps and glitches with a random consumer.
    rand_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        rxd = 1'b0;
        repeat ($urandom_range(1, CPB / 2 - 2)) tick();
        rxd = 1'b1;
        repeat (CPB) tick();
      end
      b = 8'($urandom);
      send_frame(b, 1'b1, CPB);
      exp_q.push_back(b);
      exp_rise_q.push_back(fall_cyc + LAT);
      gap = $urandom_range(0, 20);
      repeat (gap) tick();
    end
    rand_ready = 1'b0;
    data_ready = 1'b1;
    repeat (4) tick();
    while (exp_q.size() > 0) begin
      expect_byte("rnd_data", exp_q.pop_front());
      expect_rise("rnd_rise", exp_rise_q.pop_front());
    end
    check("rnd_extra_bytes", 32'(acc_q.size()), 32'd0);
    check("rnd_flags", 32'({ferr, oerr}), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
